// File: rtl/laser_bank_pkg.sv
// Shared screen/ship geometry and colour codes for the ship, alien and laser blocks.
package laser_bank_pkg;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned SHIP_WIDTH    = 60;
  localparam int unsigned SHIP_HEIGHT   = 30;
  localparam int unsigned V_OFFSET      = 10;

  localparam logic [2:0] BACKGROUND = 3'd0;
  localparam logic [2:0] LASER      = 3'd6;

  // Magnitude of a - b, taken through an 11-bit signed difference so there is no unsigned wrap.
  function automatic logic [10:0] absDiff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/laser_bank_slot.sv
// One laser slot: holds active/x/y, applies hit, launch, upward motion and top exit.
module laser_slot
  import laser_bank_pkg::*;
#(
  parameter int unsigned STEP_MOTION = 2,
  parameter int unsigned RADIUS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       launch,
  input  logic       kill,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       inSquare
);

  localparam logic [9:0]  ExitLimit = 10'(STEP_MOTION + RADIUS);
  localparam logic [9:0]  Step      = 10'(STEP_MOTION);
  localparam logic [10:0] Radius    = 11'(RADIUS);

  logic       activeQ, activeD;
  logic [9:0] xQ, xD, yQ, yD;

  // Hit beats launch and motion; launch is only ever offered to a slot that is inactive.
  always_comb begin
    activeD = activeQ;
    xD      = xQ;
    yD      = yQ;
    if (kill && activeQ) begin
      activeD = 1'b0;
    end else if (launch) begin
      activeD = 1'b1;
      xD      = x0;
      yD      = y0;
    end else if (enable && activeQ) begin
      if (yQ < ExitLimit) begin
        activeD = 1'b0;
      end else begin
        yD = yQ - Step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      activeQ <= 1'b0;
      xQ      <= '0;
      yQ      <= '0;
    end else begin
      activeQ <= activeD;
      xQ      <= xD;
      yQ      <= yD;
    end
  end

  assign active   = activeQ;
  assign x        = xQ;
  assign y        = yQ;
  assign inSquare = activeQ && (absDiff(hPos, xQ) < Radius) && (absDiff(vPos, yQ) < Radius);

endmodule

// File: rtl/laser_bank.sv
// Multi-shot player laser bank: free-slot launch, shared cooldown, registered pixel layer.
module laser_bank
  import laser_bank_pkg::*;
#(
  parameter int unsigned NUM_LASERS  = 4,
  parameter int unsigned COOLDOWN    = 16,
  parameter int unsigned STEP_MOTION = 2,
  parameter int unsigned RADIUS      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       fire,
  input  logic [NUM_LASERS-1:0]      killingAlien,
  input  logic [9:0]                 gunPosition,
  input  logic [9:0]                 hPos,
  input  logic [9:0]                 vPos,
  output logic [NUM_LASERS-1:0]      activeLasers,
  output logic [10*NUM_LASERS-1:0]   xLasers,
  output logic [10*NUM_LASERS-1:0]   yLasers,
  output logic [2:0]                 colorLaser,
  output logic                       fired
);

  localparam int unsigned CoolW = $clog2(COOLDOWN + 2);
  localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOLDOWN);
  localparam logic [9:0]  Y0       = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - RADIUS);
  localparam logic [10:0] HalfShip = 11'(SHIP_WIDTH / 2);
  localparam logic [10:0] XMax     = 11'(SCREEN_WIDTH - 1);

  logic [CoolW-1:0]      cooldownQ, cooldownD;
  logic                  firedQ;
  logic [2:0]            colorQ;
  logic [NUM_LASERS-1:0] launchVec, inSquare;
  logic                  canLaunch, found;
  logic [10:0]           xSum;
  logic [9:0]            x0;

  assign xSum = {1'b0, gunPosition} + HalfShip;
  assign x0   = (xSum > XMax) ? XMax[9:0] : xSum[9:0];

  assign canLaunch = enable && fire && (cooldownQ == '0) && !(&activeLasers);

  // Lowest-index inactive slot wins; uses pre-edge state so a same-edge free is not reused.
  always_comb begin
    launchVec = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(NUM_LASERS); i++) begin
      if (!found && !activeLasers[i]) begin
        launchVec[i] = canLaunch;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    cooldownD = cooldownQ;
    if (canLaunch) begin
      cooldownD = CoolLoad;
    end else if (enable && (cooldownQ != '0)) begin
      cooldownD = cooldownQ - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cooldownQ <= '0;
      firedQ    <= 1'b0;
      colorQ    <= BACKGROUND;
    end else begin
      cooldownQ <= cooldownD;
      firedQ    <= canLaunch;
      colorQ    <= (|inSquare) ? LASER : BACKGROUND;
    end
  end

  for (genvar i = 0; i < NUM_LASERS; i++) begin : gSlot
    laser_slot #(
      .STEP_MOTION (STEP_MOTION),
      .RADIUS      (RADIUS)
    ) uSlot (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .launch   (launchVec[i]),
      .kill     (killingAlien[i]),
      .x0       (x0),
      .y0       (Y0),
      .hPos     (hPos),
      .vPos     (vPos),
      .active   (activeLasers[i]),
      .x        (xLasers[10*i +: 10]),
      .y        (yLasers[10*i +: 10]),
      .inSquare (inSquare[i])
    );
  end

  assign fired      = firedQ;
  assign colorLaser = colorQ;

endmodule

// File: tb/tb_laser_bank.sv
// Directed bench for laser_bank: pixel vector table plus hand-written launch/motion/hit sequences.
module tb_laser_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fire = 1'b0;
  logic [3:0] killingAlien = '0;
  logic [9:0] gunPosition = '0;
  logic [9:0] hPos = '0;
  logic [9:0] vPos = '0;
  logic [3:0]  activeLasers;
  logic [39:0] xLasers;
  logic [39:0] yLasers;
  logic [2:0]  colorLaser;
  logic        fired;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] expColor;
  } pixVec_t;

  pixVec_t vecs[9];

  laser_bank dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fire         (fire),
    .killingAlien (killingAlien),
    .gunPosition  (gunPosition),
    .hPos         (hPos),
    .vPos         (vPos),
    .activeLasers (activeLasers),
    .xLasers      (xLasers),
    .yLasers      (yLasers),
    .colorLaser   (colorLaser),
    .fired        (fired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One frame tick; sawFire reports fired in the cycle following the tick edge.
  task automatic tickOnce(input logic [3:0] kill, output logic sawFire);
    enable       = 1'b1;
    killingAlien = kill;
    @(negedge clk);
    sawFire      = fired;
    enable       = 1'b0;
    killingAlien = '0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    logic f;
    for (int i = 0; i < n; i++) tickOnce(4'b0000, f);
  endtask

  function automatic logic [9:0] xOf(input int i);
    return xLasers[10*i +: 10];
  endfunction

  function automatic logic [9:0] yOf(input int i);
    return yLasers[10*i +: 10];
  endfunction

  initial begin
    logic f;
    int   launchTicks[$];

    // Slot 0 sits at (330,200) when the table is applied.
    vecs[0] = '{h: 10'd330, v: 10'd200, expColor: 3'd6};
    vecs[1] = '{h: 10'd327, v: 10'd203, expColor: 3'd6};
    vecs[2] = '{h: 10'd333, v: 10'd197, expColor: 3'd6};
    vecs[3] = '{h: 10'd326, v: 10'd200, expColor: 3'd0};
    vecs[4] = '{h: 10'd330, v: 10'd196, expColor: 3'd0};
    vecs[5] = '{h: 10'd334, v: 10'd200, expColor: 3'd0};
    vecs[6] = '{h: 10'd330, v: 10'd204, expColor: 3'd0};
    vecs[7] = '{h: 10'd0,   v: 10'd200, expColor: 3'd0};
    vecs[8] = '{h: 10'd1023, v: 10'd1023, expColor: 3'd0};

    // Reset state
    doReset();
    check("reset_active", 32'(activeLasers), 0);
    check("reset_color", 32'(colorLaser), 0);
    check("reset_fired", 32'(fired), 0);
    check("reset_xy", 32'(|{xLasers, yLasers}), 0);

    // First launch
    gunPosition = 10'd300;
    fire        = 1'b1;
    tickOnce(4'b0000, f);
    check("first_fired", 32'(f), 1);
    check("first_active", 32'(activeLasers), 32'b0001);
    check("first_x", 32'(xOf(0)), 330);
    check("first_y", 32'(yOf(0)), 436);
    check("fired_one_cycle", 32'(fired), 0);

    // Cooldown pacing with fire held; fifth request finds all busy
    doReset();
    launchTicks.delete();
    for (int t = 0; t < 71; t++) begin
      tickOnce(4'b0000, f);
      if (f) launchTicks.push_back(t);
    end
    check("launch_count", 32'(launchTicks.size()), 4);
    for (int k = 0; k < 4 && k < launchTicks.size(); k++)
      check("launch_tick", 32'(launchTicks[k]), 32'(17 * k));
    check("all_busy", 32'(activeLasers), 32'b1111);
    fire = 1'b0;
    killingAlien = 4'b0100;
    @(negedge clk);
    killingAlien = '0;
    check("hit_no_enable", 32'(activeLasers), 32'b1011);
    fire = 1'b1;
    tickOnce(4'b0000, f);
    check("no_reload_fired", 32'(f), 1);
    check("no_reload_active", 32'(activeLasers), 32'b1111);
    check("no_reload_y2", 32'(yOf(2)), 436);
    fire = 1'b0;

    // Top exit
    doReset();
    fire = 1'b1;
    tickOnce(4'b0000, f);
    fire = 1'b0;
    ticks(216);
    check("top_y", 32'(yOf(0)), 4);
    check("top_still_active", 32'(activeLasers), 32'b0001);
    tickOnce(4'b0000, f);
    check("top_exit", 32'(activeLasers), 32'b0000);
    check("top_y_kept", 32'(yOf(0)), 4);

    // Hit on the same edge as motion and launch
    doReset();
    fire = 1'b1;
    ticks(34);
    check("pre_hit_active", 32'(activeLasers), 32'b0011);
    tickOnce(4'b0010, f);
    check("hit_launch_fired", 32'(f), 1);
    check("hit_active", 32'(activeLasers), 32'b0101);
    check("hit_y1_frozen", 32'(yOf(1)), 404);
    check("hit_y0_moved", 32'(yOf(0)), 368);
    check("hit_y2_new", 32'(yOf(2)), 436);
    fire = 1'b0;

    // Pixel layer table
    doReset();
    fire = 1'b1;
    tickOnce(4'b0000, f);
    fire = 1'b0;
    ticks(118);
    check("pix_slot_y", 32'(yOf(0)), 200);
    for (int i = 0; i < 9; i++) begin
      hPos = vecs[i].h;
      vPos = vecs[i].v;
      @(negedge clk);
      check($sformatf("pix_%0d", i), 32'(colorLaser), 32'(vecs[i].expColor));
    end

    // X0 clamp at the right screen edge
    doReset();
    gunPosition = 10'd1000;
    fire = 1'b1;
    tickOnce(4'b0000, f);
    fire = 1'b0;
    check("clamp_x", 32'(xOf(0)), 639);
    gunPosition = 10'd300;

    // Asynchronous reset mid-flight
    doReset();
    fire = 1'b1;
    ticks(35);
    fire = 1'b0;
    check("three_active", 32'(activeLasers), 32'b0111);
    hPos = 10'd330;
    vPos = 10'd436;
    @(negedge clk);
    check("pre_reset_color", 32'(colorLaser), 6);
    #2 reset = 1'b1;
    #1;
    check("async_active", 32'(activeLasers), 0);
    check("async_color", 32'(colorLaser), 0);
    check("async_xy", 32'(|{xLasers, yLasers}), 0);
    @(negedge clk);
    reset = 1'b0;
    fire  = 1'b1;
    tickOnce(4'b0000, f);
    fire  = 1'b0;
    check("post_reset_fired", 32'(f), 1);
    check("post_reset_active", 32'(activeLasers), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
